data_source_multi: RTL and testbench

Parametrised multi-channel test-pattern source that feeds the CGRA input fabric. It generalises the single-channel serial source in several ways: per-channel runtime configuration, several channels sharing one output, signed ramp and constant modes, a ready/valid output handshake, and bounded or continuous bursts. Channels are interleaved round-robin onto one tagged stream. The block sits between the host configuration path and the array's input FIFOs.

---
 rtl/data_source_pkg.sv | 23 ++
 rtl/data_source_chan_gen.sv | 86 ++++++++
 rtl/data_source_multi.sv | 140 ++++++++++++++
 tb/tb_data_source_multi.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_source_pkg.sv
// Shared types for the multi-channel test-pattern source.
// Modes, FSM states and configuration register addresses.
package data_source_pkg;

  typedef enum logic [1:0] {
    CONST   = 2'd0,
    RAMP    = 2'd1,
    CHAN_ID = 2'd2,
    RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] CFG_START  = 2'd0;
  localparam logic [1:0] CFG_END    = 2'd1;
  localparam logic [1:0] CFG_STRIDE = 2'd2;
  localparam logic [1:0] CFG_MODE   = 2'd3;

endpackage

// File: rtl/data_source_chan_gen.sv
// One generator channel: config registers, ramp state and the
// current / post-advance / post-load sample for its mode.
module data_source_chan_gen
  import data_source_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CH_IDX     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic [DATA_WIDTH-1:0] adv_o,
  output logic [DATA_WIDTH-1:0] init_o
);

  localparam logic [DATA_WIDTH-1:0] ID = DATA_WIDTH'(CH_IDX);

  logic [DATA_WIDTH-1:0] start_q;
  logic [DATA_WIDTH-1:0] end_q;
  logic [DATA_WIDTH-1:0] stride_q;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] cur_q;
  logic [DATA_WIDTH-1:0] cur_nxt;
  logic [DATA_WIDTH+1:0] sum;
  logic [DATA_WIDTH+1:0] lim;
  logic                  wrap;

  // Two guard bits: signed cur plus unsigned stride cannot overflow.
  assign sum = {{2{cur_q[DATA_WIDTH-1]}}, cur_q}
             + {2'b00, stride_q};
  assign lim = {{2{end_q[DATA_WIDTH-1]}}, end_q};
  assign wrap = $signed(sum) > $signed(lim);
  assign cur_nxt = wrap ? start_q : sum[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      end_q    <= '0;
      stride_q <= DATA_WIDTH'(1);
      mode_q   <= CONST;
    end else if (cfg_we) begin
      unique case (cfg_addr)
        CFG_START:  start_q <= cfg_data;
        CFG_END:    end_q   <= cfg_data;
        CFG_STRIDE: stride_q <= (cfg_data == '0) ?
                               DATA_WIDTH'(1) : cfg_data;
        CFG_MODE:   mode_q  <= mode_e'(cfg_data[1:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
    end else if (load) begin
      cur_q <= start_q;
    end else if (advance) begin
      cur_q <= cur_nxt;
    end
  end

  always_comb begin
    value_o = start_q;
    adv_o   = start_q;
    init_o  = start_q;
    unique case (1'b1)
      mode_q == RAMP: begin
        value_o = cur_q;
        adv_o   = cur_nxt;
      end
      mode_q == CHAN_ID: begin
        value_o = ID;
        adv_o   = ID;
        init_o  = ID;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_source_multi.sv
// Multi-channel pattern source: FSM, round-robin arbitration,
// beat counter and registered ready/valid output stage.
module data_source_multi
  import data_source_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  start,
  input  logic                  stop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  busy,
  output logic                  done
);

  state_e state_q, state_d;

  logic [NUM_CH-1:0]                 en_q;
  logic [CNT_WIDTH-1:0]              blen_q;
  logic [CNT_WIDTH-1:0]              cnt_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] val_w;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] adv_w;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] init_w;
  logic                              go;
  logic                              accept;
  logic                              last;
  logic [CH_W-1:0]                   first_ch;
  logic [CH_W-1:0]                   next_ch;

  function automatic logic [CH_W-1:0] first_en(
    input logic [NUM_CH-1:0] m
  );
    first_en = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) first_en = CH_W'(i);
  endfunction

  function automatic logic [CH_W-1:0] next_en(
    input logic [NUM_CH-1:0] m,
    input logic [CH_W-1:0]   c
  );
    logic found;
    found   = 1'b0;
    next_en = first_en(m);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && m[i] && (i > int'(c))) begin
        next_en = CH_W'(i);
        found   = 1'b1;
      end
    end
  endfunction

  assign go       = (state_q == IDLE) && start && (|ch_en);
  assign accept   = out_valid && out_ready;
  assign last     = accept && (blen_q != '0)
                 && (cnt_q == blen_q - CNT_WIDTH'(1));
  assign first_ch = first_en(ch_en);
  assign next_ch  = next_en(en_q, out_ch);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    data_source_chan_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .CH_IDX     (i)
    ) u_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we && (state_q == IDLE)
                 && (cfg_ch == CH_W'(i))),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .load     (go),
      .advance  (accept && (out_ch == CH_W'(i))),
      .value_o  (val_w[i]),
      .adv_o    (adv_w[i]),
      .init_o   (init_w[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (stop)      state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A lone channel follows itself, so it needs its post-advance value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      en_q      <= '0;
      blen_q    <= '0;
      cnt_q     <= '0;
    end else begin
      out_valid <= (state_d == RUN);
      busy      <= (state_d == RUN);
      done      <= (state_d == DONE);
      if (go) begin
        en_q     <= ch_en;
        blen_q   <= burst_len;
        cnt_q    <= '0;
        out_ch   <= first_ch;
        out_data <= init_w[first_ch];
      end else if (accept) begin
        cnt_q    <= cnt_q + CNT_WIDTH'(1);
        out_ch   <= next_ch;
        out_data <= (next_ch == out_ch) ?
                    adv_w[next_ch] : val_w[next_ch];
      end
    end
  end

endmodule

// File: tb/tb_data_source_multi.sv
// Scoreboard bench for data_source_multi: directed runs with
// expected beats queued up front and a negedge monitor.
module tb_data_source_multi;
  import data_source_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int CHW = 2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_addr;
  logic [DW-1:0]  cfg_data;
  logic [NCH-1:0] ch_en;
  logic [CW-1:0]  burst_len;
  logic           start;
  logic           stop;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CHW-1:0] out_ch;
  logic           busy;
  logic           done;

  int    n_chk;
  int    n_fail;
  beat_t exp_q[$];
  beat_t mon_e;
  bit    pstall;
  logic [DW-1:0]  pdata;
  logic [CHW-1:0] pch;
  bit    pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  int    cyc;

  data_source_multi #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .CH_W       (CHW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .ch_en     (ch_en),
    .burst_len (burst_len),
    .start     (start),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CHW-1:0] c,
                      input logic [DW-1:0] d);
    beat_t b;
    b.ch   = c;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic cfg_write(input logic [CHW-1:0] c,
                           input logic [1:0] a,
                           input logic [DW-1:0] d);
    cfg_we   = 1'b1;
    cfg_ch   = c;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic start_run(input logic [NCH-1:0] en,
                           input logic [CW-1:0] bl);
    ch_en     = en;
    burst_len = bl;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget,
                           input bit tog, output int n);
    n = 0;
    while (!done && n < budget) begin
      if (tog) out_ready = pat[n % 8];
      step();
      n++;
    end
    check({nm, "_done"}, 32'(done), 1);
    check({nm, "_valid_in_done"}, 32'(out_valid), 0);
    check({nm, "_busy_in_done"}, 32'(busy), 0);
    out_ready = 1'b1;
    step();
    check({nm, "_done_one_cycle"}, 32'(done), 0);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(pdata));
        check("hold_ch", 32'(out_ch), 32'(pch));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got ch %0d data %0h, expected none",
                   out_ch, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_ch", 32'(out_ch), 32'(mon_e.ch));
          check("sb_data", 32'(out_data), 32'(mon_e.data));
        end
      end
      pstall = out_valid && !out_ready && !stop;
      pdata  = out_data;
      pch    = out_ch;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_addr  = '0;
    cfg_data  = '0;
    ch_en     = '0;
    burst_len = '0;
    start     = 1'b0;
    stop      = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();

    // RAMP wrap on a single channel
    cfg_write(0, CFG_START, 16'hFFFE);
    cfg_write(0, CFG_END, 16'd2);
    cfg_write(0, CFG_STRIDE, 16'd2);
    cfg_write(0, CFG_MODE, 16'd1);
    push(0, 16'hFFFE); push(0, 16'd0); push(0, 16'd2);
    push(0, 16'hFFFE); push(0, 16'd0); push(0, 16'd2);
    start_run(4'b0001, 16'd6);
    check("ramp_busy_at_start", 32'(busy), 1);
    check("ramp_valid_at_start", 32'(out_valid), 1);
    wait_done("ramp", 30, 1'b0, cyc);
    check("ramp_latency", cyc, 6);

    // Interleave of CHAN_ID channels, then back-to-back start
    cfg_write(0, CFG_MODE, 16'd2);
    cfg_write(2, CFG_MODE, 16'd2);
    cfg_write(1, CFG_END, 16'd3);
    cfg_write(1, CFG_MODE, 16'd1);
    push(0, 16'd0); push(2, 16'd2);
    push(0, 16'd0); push(2, 16'd2);
    start_run(4'b0101, 16'd4);
    wait_done("ileave", 30, 1'b0, cyc);
    check("ileave_latency", cyc, 4);

    // Backpressure on a 0..3 ramp
    push(1, 16'd0); push(1, 16'd1);
    push(1, 16'd2); push(1, 16'd3);
    start_run(4'b0010, 16'd4);
    wait_done("bp", 40, 1'b1, cyc);

    // Continuous run aborted on the tenth beat
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) push(0, 16'd0);
      else            push(2, 16'd2);
    end
    start_run(4'b0101, 16'd0);
    repeat (9) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    step();
    check("abort_done_later", 32'(done), 0);
    check("abort_sb_empty", exp_q.size(), 0);

    // Config lockout during RUN
    cfg_write(3, CFG_START, 16'd7);
    push(3, 16'd7); push(3, 16'd7); push(3, 16'd7);
    start_run(4'b1000, 16'd3);
    cfg_write(3, CFG_START, 16'd99);
    wait_done("lock", 30, 1'b0, cyc);
    cfg_write(3, CFG_START, 16'd99);
    push(3, 16'd99); push(3, 16'd99);
    start_run(4'b1000, 16'd2);
    wait_done("unlock", 30, 1'b0, cyc);

    // start with empty mask is ignored
    start_run(4'b0000, 16'd5);
    check("empty_mask_busy", 32'(busy), 0);
    check("empty_mask_valid", 32'(out_valid), 0);

    // Reset while beat 3 is presented
    push(1, 16'd0); push(1, 16'd1);
    start_run(4'b0010, 16'd10);
    step();
    step();
    check("pre_rst_data", 32'(out_data), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_data", 32'(out_data), 0);
    check("midrst_ch", 32'(out_ch), 0);
    check("midrst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    check("midrst_sb_empty", exp_q.size(), 0);
    step();
    push(1, 16'd0); push(1, 16'd0);
    start_run(4'b0010, 16'd2);
    wait_done("post_rst", 30, 1'b0, cyc);

    // Stride write of zero stored as one
    cfg_write(1, CFG_END, 16'd5);
    cfg_write(1, CFG_MODE, 16'd1);
    cfg_write(1, CFG_STRIDE, 16'd0);
    push(1, 16'd0); push(1, 16'd1); push(1, 16'd2);
    start_run(4'b0010, 16'd3);
    wait_done("stride0", 30, 1'b0, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
